pwm_bank: RTL and testbench
===========================

# pwm_bank

Multi-channel PWM generator: a parametrised successor to the single-channel PWM. It drives CHANNELS outputs from one shared prescaler and period counter, in either edge-aligned or center-aligned mode. Each channel's duty is double-buffered, so software can change it at any time without glitches; a new duty takes effect only at a period boundary. It sits between the register/control logic and the motor/LED drive pins.

## Interface
- WIDTH, 8, counter and duty width; MAX = 2^WIDTH-1
- CHANNELS, 4, number of PWM outputs
- PRESCALE_BITS, 4, width of the prescale input
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; one clock, async active-high reset
- enable  input  1  run when 1; hold idle when 0
- center_mode  input  1  0 = edge-aligned, 1 = center-aligned
- prescale  input  PRESCALE_BITS  a tick occurs every prescale+1 clk cycles
- duty  input  CHANNELS*WIDTH  channel i duty in bits [i*WIDTH +: WIDTH]
- duty_load  input  CHANNELS  bit i writes duty slice i into shadow[i]
- pwm_out  output  CHANNELS  registered PWM outputs
- period_start  output  1  one-clk pulse at the first cycle of each period

## Operation
- **Reset state:** pwm_out=0, period_start=0, counter=0, prescaler count=0, direction=up, all shadow and active duties=0.
- **Prescaler:**
  - Counts clk cycles while enable=1.
  - A tick is generated when the prescaler count >= prescale; the count then returns to 0.
  - A prescale change takes effect immediately; the >= compare prevents a stall.
- **Edge mode:**
  - On each tick the counter steps 0,1,…,MAX,0.
  - Channel i output = (counter < active[i]).
- **Center mode:**
  - On each tick the counter steps 0,1,…,MAX,MAX-1,…,1,0. Direction flips at MAX and at 0.
  - Channel i output = (counter < active[i]).
- **Shadow writes:** duty_load[i]=1 writes shadow[i] on that clk edge. Loads can occur at any time and in any combination of channels.
- **Boundary transfer:**
  - A boundary is the tick where the counter enters 0: edge mode on the MAX→0 wrap; center mode on the 1→0 step.
  - At a boundary, active[i] <= shadow[i] for all channels simultaneously.
  - If duty_load[i] coincides with the boundary edge, active[i] takes the pre-load shadow value. The new value takes effect at the following boundary.
- **Disabled (enable=0):**
  - Prescaler count and counter are forced to 0; direction=up.
  - pwm_out=0 and period_start=0.
  - active[i] tracks shadow[i] every cycle.
  - Shadow loads are still accepted.
- **Mode change:** a change of center_mode while enabled takes effect at the next boundary. The mode is latched with the duties. Direction is forced up at that boundary.
- **Duty limits:**
  - duty=0 gives a constant-low output.
  - Edge mode: duty=MAX gives high for MAX of MAX+1 ticks.
  - Center mode: high time is 2*duty-1 ticks for 1<=duty<=MAX, within a period of 2*MAX ticks.

## Timing
- Counter, direction, active duties, pwm_out and period_start all update on the same clk edge.
- pwm_out reflects the compare of the new counter value against the new active duty. There is no extra pipeline stage.
- Edge period = (prescale+1)*(MAX+1) clk. Center period = (prescale+1)*2*MAX clk.
- period_start=1 only for the single clk cycle following the boundary edge, not for the remaining prescale cycles at count 0.
- Enable 0→1:
  - The first period starts at that edge; counter=0 is treated as a boundary.
  - period_start pulses for one cycle.
  - pwm_out[i]=(0<active[i]) from that cycle.
- Async reset mid-period:
  - All outputs go low immediately, without waiting for clk.
  - Operation restarts from the reset state on the first edge after deassertion.

## Test plan
Run with WIDTH=4, CHANNELS=3, PRESCALE_BITS=2.
- **Reset:** assert reset for 17 ns mid-cycle, with duties preloaded → pwm_out=0, period_start=0 asynchronously. The first period starts on the first edge with enable=1 after release.
- **Edge mode:** prescale=1, duties 8/4/12 loaded while disabled, then enable.
  - Period = 32 clk.
  - High times are 16, 8 and 24 clk.
  - period_start pulses every 32 clk.
- **Duty extremes:** duty 0 → output never high. Duty 15 in edge mode, prescale=0 → high 15 of 16 clk, low exactly 1 clk per period.
- **Shadowing:**
  - Load ch0=2 mid-period → the current period keeps duty 8; the next period has a 4-clk high time (prescale=1).
  - Load ch0 on the boundary edge → the new value is delayed by one full period.
- **Center mode:** prescale=0, duty 4.
  - Counter sequence is 0..15..1.
  - Period = 30 clk, high time = 7 clk, symmetric about count 0.
- **Enable and prescale changes:**
  - Deassert enable mid-period → outputs low, counter 0.
  - Reassert → a fresh period starts with period_start.
  - Change prescale 3→0 while the prescaler count is 2 → a tick occurs on the next edge, with no stall.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel edge/center-aligned PWM with a shared prescaler and counter.
// Duties are double-buffered and transfer to the active set when the counter enters 0.
module pwm_bank #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      center_mode,
  input  logic [PRESCALE_BITS-1:0]  prescale,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       duty_load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [PRESCALE_BITS-1:0] psc;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow, active, act_nxt;
  logic [CHANNELS-1:0] pwm_nxt;
  logic run, mode, down, down_nxt, tick, bound;
  // The first enabled cycle after idle counts as a boundary so a fresh period starts there.
  always_comb begin
    tick = psc >= prescale;
    bound = !run || (tick && (mode ? down && cnt == ONE : cnt == MAX));
    cnt_nxt = bound ? '0 : !tick ? cnt : (mode && (down || cnt == MAX)) ? cnt - ONE : cnt + ONE;
    down_nxt = !bound && (down || (tick && mode && cnt == MAX));
    act_nxt = bound ? shadow : active;
    pwm_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) pwm_nxt[i] = cnt_nxt < act_nxt[i];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      psc <= '0;
      cnt <= '0;
      down <= 1'b0;
      mode <= 1'b0;
      run <= 1'b0;
      shadow <= '0;
      active <= '0;
      pwm_out <= '0;
      period_start <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (duty_load[i]) shadow[i] <= duty[i*WIDTH +: WIDTH];
      run <= enable;
      psc <= (!enable || bound || tick) ? '0 : psc + 1'b1;
      cnt <= enable ? cnt_nxt : '0;
      down <= enable && down_nxt;
      mode <= (!enable || bound) ? center_mode : mode;
      active <= enable ? act_nxt : shadow;
      pwm_out <= enable ? pwm_nxt : '0;
      period_start <= enable && bound;
    end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed bench for pwm_bank; a period-position model is compared every cycle,
// and measured periods/high times are pinned against hand-computed values.
module tb_pwm_bank;
  localparam int W = 4, C = 3, PB = 2, MAX = 15;
  logic clk = 0, reset = 0, enable = 0, center_mode = 0;
  logic [PB-1:0] prescale = 0;
  logic [C*W-1:0] duty = 0;
  logic [C-1:0] duty_load = 0;
  logic [C-1:0] pwm_out;
  logic period_start;
  int checks = 0, failures = 0;
  int m_shadow[C], m_active[C], old_shadow[C];
  int m_pos = 0, m_sub = 0, cval = 0;
  bit m_run = 0, m_mode = 0, m_start = 0;
  logic [C-1:0] exp_pwm = 0;
  logic exp_ps = 0;
  int len, hi[C];

  pwm_bank #(.WIDTH(W), .CHANNELS(C), .PRESCALE_BITS(PB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .center_mode(center_mode),
    .prescale(prescale), .duty(duty), .duty_load(duty_load),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: position within the period in ticks, clk count within the tick.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_run = 0; m_mode = 0; m_pos = 0; m_sub = 0; exp_pwm = '0; exp_ps = 0;
      for (int i = 0; i < C; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    end else begin
      old_shadow = m_shadow;
      for (int i = 0; i < C; i++) if (duty_load[i]) m_shadow[i] = int'(duty[i*W +: W]);
      if (!enable) begin
        m_run = 0; m_pos = 0; m_sub = 0; m_active = old_shadow; m_mode = center_mode;
        exp_pwm = '0; exp_ps = 0;
      end else begin
        m_start = !m_run;
        if (m_run) begin
          if (m_sub >= int'(prescale)) begin
            m_sub = 0;
            m_pos++;
            m_start = m_pos == (m_mode ? 2*MAX : MAX+1);
          end else m_sub++;
        end
        if (m_start) begin
          m_pos = 0; m_sub = 0; m_active = old_shadow; m_mode = center_mode;
        end
        m_run = 1;
        cval = (m_mode && m_pos > MAX) ? 2*MAX - m_pos : m_pos;
        for (int i = 0; i < C; i++) exp_pwm[i] = cval < m_active[i];
        exp_ps = m_start;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("pwm_vs_model", int'(pwm_out), int'(exp_pwm));
    check("ps_vs_model", int'(period_start), int'(exp_ps));
  end

  // Measures one full period starting at a period_start sample; optionally loads a duty at index load_at.
  task automatic measure(input int load_at, input int ch, input int val);
    int k = 0;
    len = 0;
    for (int i = 0; i < C; i++) hi[i] = 0;
    while (!period_start && k < 300) begin @(negedge clk); k++; end
    check("ps_seen", int'(period_start), 1);
    do begin
      for (int i = 0; i < C; i++) hi[i] += int'(pwm_out[i]);
      duty_load = '0;
      if (len == load_at) begin duty[ch*W +: W] = val[W-1:0]; duty_load[ch] = 1'b1; end
      len++;
      @(negedge clk);
    end while (!period_start && len < 300);
    duty_load = '0;
  endtask

  task automatic load(input int ch, input int val);
    duty[ch*W +: W] = val[W-1:0];
    duty_load = '0;
    duty_load[ch] = 1'b1;
    @(negedge clk);
    duty_load = '0;
  endtask

  initial begin
    #2 reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    prescale = 1;
    duty = {4'd12, 4'd4, 4'd8};
    duty_load = '1;
    @(negedge clk);
    duty_load = '0;
    repeat (3) @(negedge clk);
    check("idle_pwm", int'(pwm_out), 0);
    enable = 1;
    @(negedge clk);
    check("en_ps", int'(period_start), 1);
    check("en_pwm", int'(pwm_out), 7);
    measure(-1, 0, 0);
    check("edge_len", len, 32);
    check("edge_hi0", hi[0], 16);
    check("edge_hi1", hi[1], 8);
    check("edge_hi2", hi[2], 24);
    measure(-1, 0, 0);
    check("edge_len2", len, 32);
    measure(10, 0, 2);
    check("mid_load_cur_hi0", hi[0], 16);
    measure(-1, 0, 0);
    check("mid_load_next_hi0", hi[0], 4);
    measure(31, 0, 6);
    check("bnd_load_cur_hi0", hi[0], 4);
    measure(-1, 0, 0);
    check("bnd_load_next_hi0", hi[0], 4);
    measure(-1, 0, 0);
    check("bnd_load_after_hi0", hi[0], 12);
    prescale = 0;
    load(1, 15);
    measure(-1, 0, 0);
    check("max_len", len, 16);
    check("max_hi1", hi[1], 15);
    check("max_hi0", hi[0], 6);
    center_mode = 1;
    load(0, 4);
    measure(-1, 0, 0);
    check("ctr_len", len, 30);
    check("ctr_hi0", hi[0], 7);
    check("ctr_hi1", hi[1], 29);
    check("ctr_hi2", hi[2], 23);
    repeat (7) @(negedge clk);
    enable = 0;
    @(negedge clk);
    check("dis_pwm", int'(pwm_out), 0);
    check("dis_ps", int'(period_start), 0);
    repeat (3) @(negedge clk);
    enable = 1;
    @(negedge clk);
    check("reen_ps", int'(period_start), 1);
    check("reen_pwm", int'(pwm_out), 7);
    measure(-1, 0, 0);
    check("reen_len", len, 30);
    prescale = 3;
    load(0, 1);
    measure(-1, 0, 0);
    check("psc3_len", len, 120);
    check("psc3_hi0", hi[0], 4);
    repeat (2) @(negedge clk);
    check("pre_change_ch0", int'(pwm_out[0]), 1);
    prescale = 0;
    @(negedge clk);
    check("no_stall_ch0", int'(pwm_out[0]), 0);
    check("pre_reset_ch1", int'(pwm_out[1]), 1);
    #2 reset = 1;
    #1;
    check("async_rst_pwm", int'(pwm_out), 0);
    check("async_rst_ps", int'(period_start), 0);
    #16 reset = 0;
    @(negedge clk);
    check("post_rst_ps0", int'(period_start), 0);
    @(negedge clk);
    check("post_rst_ps1", int'(period_start), 1);
    check("post_rst_pwm", int'(pwm_out), 0);
    measure(-1, 0, 0);
    check("zero_len", len, 30);
    check("zero_hi0", hi[0], 0);
    check("zero_hi1", hi[1], 0);
    check("zero_hi2", hi[2], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
